// File: rtl/sram_burst_ctrl.sv
// Burst controller that owns the single port of one sram_sp buffer.
// Streams write beats into the SRAM and read beats out through a 2-entry return buffer.
//
// state | meaning
// IDLE  | waiting for a burst command, cmd_ready high
// WRITE | accepting wr_data beats, one SRAM write per handshake
// READ  | issuing SRAM reads and draining the return buffer
module sram_burst_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam int CNT_WIDTH = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cur_addr, addr_inc;
    logic [CNT_WIDTH-1:0]  beats, issued;
    logic                  inflight, inflight_last;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic [1:0]            buf_count;
    logic                  head, tail;
    logic [2:0]            occupancy;
    logic                  cmd_fire, wr_fire, rd_issue, rd_pop, issue_last;

    // Explicit compare so non-power-of-two depths wrap correctly.
    assign addr_inc   = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
    assign issue_last = (issued == beats - 1'b1);

    assign cmd_ready  = (state == IDLE) && !rst;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign wr_ready   = (state == WRITE);
    assign wr_fire    = wr_valid && wr_ready;

    assign rd_valid   = (buf_count != 2'd0);
    assign rd_data    = buf_data[head];
    assign rd_last    = buf_last[head];
    assign rd_pop     = rd_valid && rd_ready;

    // Slots committed after this cycle's pop; a new issue needs one free.
    assign occupancy  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, rd_pop};
    assign rd_issue   = (state == READ) && (issued < beats) && (occupancy < 3'd2);

    assign mem_en     = wr_fire || rd_issue;
    assign mem_we     = wr_fire;
    assign mem_addr   = cur_addr;
    assign mem_wdata  = wr_data;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = cmd_write ? WRITE : READ;
            WRITE:   if (wr_fire && issue_last) state_next = IDLE;
            READ:    if (rd_pop && rd_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            beats    <= '0;
            issued   <= '0;
        end else begin
            state <= state_next;
            if (cmd_fire) begin
                cur_addr <= cmd_addr;
                beats    <= {1'b0, cmd_len} + 1'b1;
                issued   <= '0;
            end else if (wr_fire || rd_issue) begin
                cur_addr <= addr_inc;
                issued   <= issued + 1'b1;
            end
        end
    end

    // Return buffer: capture SRAM data the cycle after each read issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= '0;
            buf_count     <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && issue_last;
            if (inflight) begin
                buf_data[tail] <= mem_rdata;
                buf_last[tail] <= inflight_last;
                tail           <= ~tail;
            end
            if (rd_pop) head <= ~head;
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, rd_pop};
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed and randomized bench for sram_burst_ctrl against an array-based memory model.
module tb_sram_burst_ctrl;

    localparam int DW    = 128;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          busy, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port SRAM with 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue_cmd(input logic w, input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        #1 check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        check("busy_after_accept", busy, 1);
    endtask

    // mode 0: back-to-back, 1: valid toggling 1,0,1,0..., 2: random gaps
    task automatic write_burst(input int addr, input int len, input int mode);
        int a   = addr;
        int n   = 0;
        int cyc = 0;
        issue_cmd(1'b1, addr, len);
        while (n <= len && cyc < 4 * (len + 1) + 50) begin
            @(negedge clk);
            case (mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = (cyc % 2 == 0);
                default: wr_valid = 1'($urandom_range(0, 1));
            endcase
            wr_data = rnd128();
            #1;
            check("wr_ready", wr_ready, 1);
            check("wr_mem_en", mem_en, wr_valid);
            if (wr_valid) begin
                check("wr_mem_we", mem_we, 1);
                check("wr_mem_addr", mem_addr, a);
                check("wr_mem_wdata", mem_wdata, wr_data);
                ref_mem[a] = wr_data;
                a = (a + 1) % DEPTH;
                n++;
            end
            cyc++;
        end
        if (n != len + 1) check("wr_timeout_beats", n, len + 1);
        @(negedge clk);
        wr_valid = 1'b1;
        #1;
        check("wr_done_cmd_ready", cmd_ready, 1);
        check("wr_done_busy", busy, 0);
        check("wr_ignored_ready", wr_ready, 0);
        check("wr_ignored_mem_en", mem_en, 0);
        wr_valid = 1'b0;
    endtask

    // mode 0: rd_ready=1, 1: 6-cycle stall after first beat, 2: random rd_ready
    task automatic read_burst(input int addr, input int len, input int mode);
        int k           = 0;
        int c           = 0;
        int iss         = 0;
        int iaddr       = addr;
        int stall_start = -1;
        issue_cmd(1'b0, addr, len);
        while (k <= len && c < 8 * (len + 1) + 100) begin
            @(negedge clk);
            c++;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = !(stall_start >= 0 && c > stall_start && c <= stall_start + 6);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (mode == 0) check("rd_valid_timing", rd_valid, (c >= 3 && c <= 3 + len));
            if (mode == 1 && stall_start >= 0 && c >= stall_start + 2 && c <= stall_start + 6)
                check("rd_mem_en_stalled", mem_en, 0);
            if (mem_en) begin
                check("rd_issue_we", mem_we, 0);
                check("rd_issue_addr", mem_addr, iaddr);
                check("rd_outstanding_le2", (iss - k + 1 - int'(rd_valid && rd_ready)) <= 2, 1);
                iss++;
                iaddr = (iaddr + 1) % DEPTH;
            end
            if (rd_valid) begin
                check("rd_data", rd_data, ref_mem[(addr + k) % DEPTH]);
                check("rd_last", rd_last, k == len);
                if (rd_ready) begin
                    if (k == 0) stall_start = c;
                    k++;
                end
            end
        end
        if (k != len + 1) check("rd_timeout_beats", k, len + 1);
        check("rd_issue_count", iss, len + 1);
        @(negedge clk);
        rd_ready = 1'b1;
        #1;
        check("rd_done_busy", busy, 0);
        check("rd_done_cmd_ready", cmd_ready, 1);
        check("rd_done_valid", rd_valid, 0);
    endtask

    initial begin
        int addr, len;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_cmd_ready", cmd_ready, 1);

        write_burst(10, 3, 0);
        read_burst(10, 3, 0);
        read_burst(10, 3, 1);
        write_burst(200, 3, 1);
        read_burst(200, 3, 2);
        write_burst(DEPTH - 2, 3, 0);
        read_burst(DEPTH - 2, 3, 0);

        // Reset in the middle of an 8-beat read.
        write_burst(100, 7, 2);
        issue_cmd(1'b0, 100, 7);
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_mem_en", mem_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_rd_last", rd_last, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_cmd_ready", cmd_ready, 1);
        read_burst(103, 0, 0);

        for (int i = 0; i < 6; i++) begin
            addr = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 40);
            write_burst(addr, len, $urandom_range(0, 2));
            read_burst(addr, len, $urandom_range(0, 2));
        end

        write_burst(1900, 255, 2);
        read_burst(1900, 255, 2);
        read_burst(1900, 255, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Initiator-side controller that owns the single port of one sram_sp weight/activation buffer.
- Accepts burst commands (write or read, start address, length) from the DMA/compute side. Moves write beats from a valid/ready stream into the SRAM and returns read beats on a valid/ready stream with full backpressure.
- Absorbs the SRAM's fixed 1-cycle read latency with a 2-entry return buffer, so it sustains 1 beat/cycle in both directions.

Parameters:
- DATA_WIDTH, 128: SRAM word and stream beat width.
- DEPTH, 2048: SRAM words.
- ADDR_WIDTH, $clog2(DEPTH): SRAM address width.
- LEN_WIDTH, 8: burst length field width; beats = cmd_len+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_WIDTH  start word address; must be < DEPTH.
- cmd_len  in  LEN_WIDTH  beats minus one.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_WIDTH  write beat.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  downstream accepts read beat.
- rd_data  out  DATA_WIDTH  read beat.
- rd_last  out  1  final beat of read burst.
- busy  out  1  state != IDLE.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read issue.

Behaviour:
- Reset (async, any state): state=IDLE, return buffer emptied, in-flight read discarded, address/beat counters=0.
  - Outputs during and after reset: rd_valid=0, rd_last=0, rd_data=0, wr_ready=0, mem_en=0, mem_we=0, busy=0, cmd_ready=1 (once rst deasserts).
- FSM IDLE/WRITE/READ.
  - cmd_ready=1 only in IDLE.
  - On accept: latch addr into cur_addr, beats=cmd_len+1; go to WRITE if cmd_write, else READ.
- WRITE:
  - wr_ready=1.
  - On each wr_valid&&wr_ready, same cycle: mem_en=1, mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data. cur_addr increments and issued count increments.
  - After the final beat, go to IDLE; cmd_ready=1 the next cycle.
  - No mem_en on cycles without wr_valid.
- READ:
  - Issue when issued < beats and (buf_count + inflight - pop) < 2, where pop = rd_valid&&rd_ready in the same cycle.
  - Issue drives mem_en=1, mem_we=0, mem_addr=cur_addr, then cur_addr++.
  - mem_rdata is captured into the buffer at the end of the following cycle, tagged last if it is beat beats-1.
  - Buffer head drives rd_data/rd_last; rd_valid=buffer non-empty.
  - Latency: accept at T, first issue at T+1, rd_valid at T+3. Steady state is 1 beat/cycle while rd_ready=1.
  - Leave for IDLE on pop of the rd_last beat.
- Address wrap: cur_addr goes DEPTH-1 -> 0 (explicit compare; DEPTH need not be a power of two).
- Outside WRITE: wr_ready=0 and wr_valid is ignored.
- rd_valid, once high, holds with rd_data/rd_last stable until popped.
- At most 2 reads outstanding (buffered + in flight); no data dropped under any rd_ready pattern.
- mem_wdata=wr_data combinationally at all times; mem_addr=cur_addr at all times.
- Burst of 2^LEN_WIDTH beats (cmd_len all ones) is supported.

Test Plan:
- Write, DEPTH=2048: cmd addr 10 len 3, wr_data A0..A3 back-to-back -> mem writes at 10,11,12,13 on 4 consecutive cycles; cmd_ready=1 the cycle after the last beat.
- Read, rd_ready=1: cmd addr 10 len 3 after the write above, accept at T -> rd_valid at T+3..T+6 with A0..A3; rd_last only with A3; busy drops at T+7.
- Backpressure: same read, rd_ready=0 for 6 cycles after the first beat -> never more than 2 reads outstanding; mem_en low while stalled; A1..A3 delivered in order once rd_ready=1.
- Write with wr_valid toggling 1,0,1,0 -> mem_en asserted only on valid cycles; addresses contiguous.
- Wrap, DEPTH=16: write addr 14 len 3 -> addresses 14,15,0,1; read back returns identical data.
- Reset asserted 2 cycles into an 8-beat read -> rd_valid=0 and mem_en=0 immediately. After release: cmd_ready=1; a new read of len 0 returns the correct single beat with rd_last=1.
